// File: rtl/decode_ctrl_stage.sv
// Registered MIPS decode stage: decodes one instruction per cycle into the datapath
// control word, with valid/ready handshake, stall, flush and a HI/LO busy sequencer.
// Ports:
//   Clk, Rst                          clock, synchronous active-high reset
//   Instruction, InValid, InReady     IF/ID side handshake (InReady is combinational)
//   Stall, Flush                      hold / kill the registered entry
//   OutValid, InstructionToALU        registered entry towards the ALU stage
//   RegWrite..MoveOnNotZero           registered control word
//   MulBusy, IllegalOp                HI/LO op in flight, illegal-op pulse
module decode_ctrl_stage #(
  parameter int INSTR_W     = 32,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3,
  parameter int ENABLE_MADD = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               InValid,
  output logic               InReady,
  input  logic               Stall,
  input  logic               Flush,
  output logic               OutValid,
  output logic [INSTR_W-1:0] InstructionToALU,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic               RegDst,
  output logic               HiLoWrite,
  output logic               Madd,
  output logic               Msub,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               Branch,
  output logic               MemToReg,
  output logic               HiToReg,
  output logic               DontMove,
  output logic               MoveOnNotZero,
  output logic               MulBusy,
  output logic               IllegalOp
);

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic reg_dst;
    logic hilo_write;
    logic madd;
    logic msub;
    logic mem_write;
    logic mem_read;
    logic branch;
    logic mem_to_reg;
    logic hi_to_reg;
    logic dont_move;
    logic move_on_nz;
  } ctrl_t;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } seq_e;

  // Decoded default: no writes, ALU result to the register file, no move.
  localparam ctrl_t NOP_W = 13'b0000000001010;
  localparam ctrl_t RST_W = 13'b0000000000010;

  localparam bit MADD_EN = (ENABLE_MADD != 0);
  localparam bit MULTI   = (MUL_LATENCY > 1);

  localparam logic [5:0] OP_SP2 = 6'h1C;
  localparam logic [5:0] OP_SP3 = 6'h1F;

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = Instruction[31:26];
  assign funct = Instruction[5:0];

  logic is_nop;
  logic is_rtype;
  logic is_imm;
  logic is_lw;
  logic is_sw;
  logic is_br;
  logic is_sp2;
  logic is_sp3;

  assign is_nop   = (Instruction == '0);
  assign is_rtype = (op == 6'h00) && !is_nop;
  assign is_imm   = (op >= 6'h08) && (op <= 6'h0E);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_br    = (op == 6'h04) || (op == 6'h05);
  assign is_sp2   = (op == OP_SP2);
  assign is_sp3   = (op == OP_SP3);

  // Hazard detection is purely syntactic: madd/msub encodings block
  // even when they would decode as illegal.
  logic hilo_user;
  logic starts_mul;

  assign hilo_user =
    ((op == 6'h00) &&
     (funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19})) ||
    (is_sp2 && (funct inside {6'h00, 6'h04}));

  assign starts_mul =
    ((op == 6'h00) && (funct inside {6'h18, 6'h19})) ||
    (MADD_EN && is_sp2 && (funct inside {6'h00, 6'h04}));

  seq_e             st_q;
  seq_e             st_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;

  logic hazard;
  logic accept;

  assign MulBusy = (st_q == S_BUSY);
  assign hazard  = MulBusy && hilo_user;
  assign InReady = !Rst && !Flush && !Stall && !hazard;
  assign accept  = InValid && InReady;

  ctrl_t dec;
  logic  dec_ill;

  always_comb begin
    dec     = NOP_W;
    dec_ill = 1'b0;
    unique case (1'b1)
      is_nop: begin
        dec = NOP_W;
      end
      is_rtype: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          6'h18, 6'h19, 6'h11, 6'h13: begin
            dec.reg_write  = 1'b0;
            dec.hilo_write = 1'b1;
          end
          6'h10: dec.hi_to_reg = 1'b1;
          6'h0B: begin
            dec.dont_move  = 1'b0;
            dec.move_on_nz = 1'b1;
          end
          6'h0A: dec.dont_move = 1'b0;
          6'h00, 6'h02, 6'h03, 6'h04,
          6'h06, 6'h07, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
          end
          default: dec_ill = 1'b1;
        endcase
      end
      is_imm: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_lw: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b0;
        dec.reg_write  = 1'b1;
      end
      is_sw: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      is_br: begin
        dec.branch = 1'b1;
      end
      is_sp2: begin
        case (funct)
          6'h02: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
          end
          6'h00: begin
            if (MADD_EN) dec.madd = 1'b1;
            else dec_ill = 1'b1;
          end
          6'h04: begin
            if (MADD_EN) dec.msub = 1'b1;
            else dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      is_sp3: begin
        if (funct == 6'h20) begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec = NOP_W;
  end

  ctrl_t              cw_q;
  ctrl_t              cw_bub;
  logic               vld_q;
  logic               ill_q;
  logic [INSTR_W-1:0] ins_q;

  // A bubble keeps the data-path selects and drops only the write enables.
  always_comb begin
    cw_bub            = cw_q;
    cw_bub.reg_write  = 1'b0;
    cw_bub.hilo_write = 1'b0;
    cw_bub.madd       = 1'b0;
    cw_bub.msub       = 1'b0;
    cw_bub.mem_write  = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cw_q  <= RST_W;
      ins_q <= '0;
    end else if (Flush) begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cw_q  <= cw_bub;
    end else if (Stall) begin
      ill_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      ill_q <= dec_ill;
      cw_q  <= dec;
      ins_q <= Instruction;
    end else begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cw_q  <= cw_bub;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
    end
  end

  // The HI/LO unit keeps counting through stalls and flushes.
  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    unique case (st_q)
      S_IDLE: begin
        if (MULTI && accept && starts_mul) begin
          st_n  = S_BUSY;
          cnt_n = CNT_W'(MUL_LATENCY - 1);
        end
      end
      S_BUSY: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) st_n = S_IDLE;
      end
    endcase
  end

  assign OutValid         = vld_q;
  assign IllegalOp        = ill_q;
  assign InstructionToALU = ins_q;
  assign RegWrite         = cw_q.reg_write;
  assign ALUSrc           = cw_q.alu_src;
  assign RegDst           = cw_q.reg_dst;
  assign HiLoWrite        = cw_q.hilo_write;
  assign Madd             = cw_q.madd;
  assign Msub             = cw_q.msub;
  assign MemWrite         = cw_q.mem_write;
  assign MemRead          = cw_q.mem_read;
  assign Branch           = cw_q.branch;
  assign MemToReg         = cw_q.mem_to_reg;
  assign HiToReg          = cw_q.hi_to_reg;
  assign DontMove         = cw_q.dont_move;
  assign MoveOnNotZero    = cw_q.move_on_nz;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: decode table, directed handshake/HI/LO
// sequences, and random traffic against a cycle-level reference model.
module tb_decode_ctrl_stage;

  localparam int INSTR_W = 32;
  localparam int LAT     = 4;

  // control word bit positions, MSB first as on the DUT port list
  localparam int RW = 12, AS = 11, RD = 10, HL = 9, MA = 8, MS = 7;
  localparam int MW = 6, MR = 5, BR = 4, MT = 3, HT = 2, DM = 1, MN = 0;
  localparam logic [12:0] NOPW = 13'b0000000001010;
  localparam logic [12:0] RSTW = 13'b0000000000010;
  localparam logic [12:0] WEM  = 13'b1001111000000;

  localparam logic [31:0] I_ADDI = 32'h20090005;
  localparam logic [31:0] I_MULT = 32'h01090018;
  localparam logic [31:0] I_MFLO = 32'h00004012;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_MADD = 32'h71090000;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [31:0] Instruction = '0;
  logic InValid = 1'b0;
  logic Stall = 1'b0;
  logic Flush = 1'b0;

  logic InReady, OutValid, MulBusy, IllegalOp;
  logic [31:0] InstructionToALU;
  logic RegWrite, ALUSrc, RegDst, HiLoWrite, Madd, Msub, MemWrite;
  logic MemRead, Branch, MemToReg, HiToReg, DontMove, MoveOnNotZero;

  logic d2_InReady, d2_OutValid, d2_MulBusy, d2_IllegalOp;
  logic [31:0] d2_InstructionToALU;
  logic d2_RegWrite, d2_ALUSrc, d2_RegDst, d2_HiLoWrite, d2_Madd;
  logic d2_Msub, d2_MemWrite, d2_MemRead, d2_Branch, d2_MemToReg;
  logic d2_HiToReg, d2_DontMove, d2_MoveOnNotZero;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  decode_ctrl_stage #(
    .INSTR_W(INSTR_W), .MUL_LATENCY(LAT), .CNT_W(3), .ENABLE_MADD(1)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction),
    .InValid(InValid), .InReady(InReady),
    .Stall(Stall), .Flush(Flush),
    .OutValid(OutValid), .InstructionToALU(InstructionToALU),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .HiLoWrite(HiLoWrite), .Madd(Madd), .Msub(Msub),
    .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch),
    .MemToReg(MemToReg), .HiToReg(HiToReg), .DontMove(DontMove),
    .MoveOnNotZero(MoveOnNotZero), .MulBusy(MulBusy),
    .IllegalOp(IllegalOp)
  );

  decode_ctrl_stage #(
    .INSTR_W(INSTR_W), .MUL_LATENCY(LAT), .CNT_W(3), .ENABLE_MADD(0)
  ) dut2 (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction),
    .InValid(InValid), .InReady(d2_InReady),
    .Stall(Stall), .Flush(Flush),
    .OutValid(d2_OutValid), .InstructionToALU(d2_InstructionToALU),
    .RegWrite(d2_RegWrite), .ALUSrc(d2_ALUSrc), .RegDst(d2_RegDst),
    .HiLoWrite(d2_HiLoWrite), .Madd(d2_Madd), .Msub(d2_Msub),
    .MemWrite(d2_MemWrite), .MemRead(d2_MemRead), .Branch(d2_Branch),
    .MemToReg(d2_MemToReg), .HiToReg(d2_HiToReg),
    .DontMove(d2_DontMove), .MoveOnNotZero(d2_MoveOnNotZero),
    .MulBusy(d2_MulBusy), .IllegalOp(d2_IllegalOp)
  );

  function automatic logic [12:0] cw1();
    return {RegWrite, ALUSrc, RegDst, HiLoWrite, Madd, Msub,
            MemWrite, MemRead, Branch, MemToReg, HiToReg,
            DontMove, MoveOnNotZero};
  endfunction

  function automatic logic [12:0] cw2();
    return {d2_RegWrite, d2_ALUSrc, d2_RegDst, d2_HiLoWrite, d2_Madd,
            d2_Msub, d2_MemWrite, d2_MemRead, d2_Branch, d2_MemToReg,
            d2_HiToReg, d2_DontMove, d2_MoveOnNotZero};
  endfunction

  // {OutValid, IllegalOp, MulBusy, control word, InstructionToALU}
  function automatic logic [47:0] obs1();
    return {OutValid, IllegalOp, MulBusy, cw1(), InstructionToALU};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    InValid = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    tick();
    Rst = 1'b0;
  endtask

  // Reference decode: {illegal, control word} from the opcode rules.
  function automatic logic [13:0] model_dec(input logic [31:0] i,
                                            input bit madd_en);
    logic [5:0] op;
    logic [5:0] fn;
    logic [12:0] w;
    bit ill;
    op = i[31:26];
    fn = i[5:0];
    w = NOPW;
    ill = 0;
    if (i == 32'h0) begin
      w = NOPW;
    end else if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                     6'h0A, 6'h0B, 6'h10, 6'h11, 6'h12, 6'h13,
                     6'h18, 6'h19, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        w[RW] = 1;
        w[RD] = 1;
        if (fn inside {6'h18, 6'h19, 6'h11, 6'h13}) begin
          w[RW] = 0;
          w[HL] = 1;
        end
        if (fn == 6'h10) w[HT] = 1;
        if (fn == 6'h0B) begin
          w[DM] = 0;
          w[MN] = 1;
        end
        if (fn == 6'h0A) w[DM] = 0;
      end else ill = 1;
    end else if (op inside {[6'h08:6'h0E]}) begin
      w[AS] = 1;
      w[RW] = 1;
    end else if (op == 6'h23) begin
      w[AS] = 1;
      w[MR] = 1;
      w[MT] = 0;
      w[RW] = 1;
    end else if (op == 6'h2B) begin
      w[AS] = 1;
      w[MW] = 1;
    end else if (op inside {6'h04, 6'h05}) begin
      w[BR] = 1;
    end else if (op == 6'h1C && fn == 6'h02) begin
      w[RW] = 1;
      w[RD] = 1;
    end else if (op == 6'h1C && fn == 6'h00 && madd_en) begin
      w[MA] = 1;
    end else if (op == 6'h1C && fn == 6'h04 && madd_en) begin
      w[MS] = 1;
    end else if (op == 6'h1F && fn == 6'h20) begin
      w[RW] = 1;
      w[RD] = 1;
    end else begin
      ill = 1;
    end
    if (ill) w = NOPW;
    return {ill, w};
  endfunction

  function automatic bit hilo_user(input logic [31:0] i);
    return (i[31:26] == 6'h00 &&
            i[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19}) ||
           (i[31:26] == 6'h1C && i[5:0] inside {6'h00, 6'h04});
  endfunction

  function automatic bit starts_mul(input logic [31:0] i);
    return (i[31:26] == 6'h00 && i[5:0] inside {6'h18, 6'h19}) ||
           (i[31:26] == 6'h1C && i[5:0] inside {6'h00, 6'h04});
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [5:0] f;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: return 32'h0;
      1: return {6'h00, r[25:0]};
      2: return {6'h00, r[25:6], r[0] ? 6'h18 : 6'h19};
      3: begin
        f = 6'h10 + 6'($urandom_range(0, 3));
        return {6'h00, r[25:6], f};
      end
      4: begin
        f = 6'h08 + 6'($urandom_range(0, 6));
        return {f, r[25:0]};
      end
      5: return {6'h23, r[25:0]};
      6: return {6'h2B, r[25:0]};
      7: return {r[0] ? 6'h04 : 6'h05, r[25:0]};
      8: begin
        f = 6'($urandom_range(0, 2)) << 1;
        return {6'h1C, r[25:6], f};
      end
      9: return {6'h1F, r[25:6], r[1] ? 6'h20 : r[5:0]};
      10: return r;
      default: return {6'h3F, r[25:0]};
    endcase
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [12:0] cw;
    logic        ill;
    string       nm;
  } vec_t;

  vec_t tbl[16];

  // model state for the random phase
  bit          m_vld;
  bit          m_ill;
  logic [12:0] m_cw;
  logic [31:0] m_ins;
  int          m_busy;

  function automatic logic [47:0] mobs();
    return {m_vld, m_ill, (m_busy > 0), m_cw, m_ins};
  endfunction

  task automatic rstep();
    logic [31:0] ins;
    logic [13:0] d;
    bit v, s, f, r, rdy, acc;
    chk("rand_out", 64'(obs1()), 64'(mobs()));
    r = ($urandom_range(0, 49) == 0);
    f = ($urandom_range(0, 11) == 0);
    s = ($urandom_range(0, 5) == 0);
    v = ($urandom_range(0, 3) != 0);
    ins = rnd_instr();
    Rst = r;
    Flush = f;
    Stall = s;
    InValid = v;
    Instruction = ins;
    #1;
    rdy = !r && !f && !s && !((m_busy > 0) && hilo_user(ins));
    chk("rand_rdy", 64'(InReady), 64'(rdy));
    acc = v && rdy;
    d = model_dec(ins, 1'b1);
    if (r) begin
      m_vld = 0;
      m_ill = 0;
      m_cw = RSTW;
      m_ins = '0;
      m_busy = 0;
    end else begin
      if (m_busy > 0) m_busy--;
      else if (acc && starts_mul(ins) && LAT > 1) m_busy = LAT - 1;
      m_ill = 0;
      if (f || (!s && !acc)) begin
        m_vld = 0;
        m_cw = m_cw & ~WEM;
      end else if (!s) begin
        m_vld = 1;
        m_cw = d[12:0];
        m_ins = ins;
        m_ill = d[13];
      end
    end
    tick();
  endtask

  initial begin
    if (INSTR_W != 32) $fatal(1, "INSTR_W must be 32");
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{32'h00000000, 13'b0000000001010, 1'b0, "nop"};
    tbl[1]  = '{I_ADDI,       13'b1100000001010, 1'b0, "addi"};
    tbl[2]  = '{32'h01095020, 13'b1010000001010, 1'b0, "add"};
    tbl[3]  = '{I_LW,         13'b1100000100010, 1'b0, "lw"};
    tbl[4]  = '{32'hAD090004, 13'b0100001001010, 1'b0, "sw"};
    tbl[5]  = '{32'h11090003, 13'b0000000011010, 1'b0, "beq"};
    tbl[6]  = '{I_MULT,       13'b0011000001010, 1'b0, "mult"};
    tbl[7]  = '{32'h0109500B, 13'b1010000001001, 1'b0, "movn"};
    tbl[8]  = '{32'h0109500A, 13'b1010000001000, 1'b0, "movz"};
    tbl[9]  = '{32'h00005010, 13'b1010000001110, 1'b0, "mfhi"};
    tbl[10] = '{32'h71095002, 13'b1010000001010, 1'b0, "mul"};
    tbl[11] = '{I_MADD,       13'b0000100001010, 1'b0, "madd"};
    tbl[12] = '{32'h71090004, 13'b0000010001010, 1'b0, "msub"};
    tbl[13] = '{32'h7C095420, 13'b1010000001010, 1'b0, "seb"};
    tbl[14] = '{I_ILL,        13'b0000000001010, 1'b1, "op3f"};
    tbl[15] = '{32'h3109FFFF, 13'b1100000001010, 1'b0, "andi"};

    // reset held two cycles with a valid instruction offered
    Rst = 1'b1;
    InValid = 1'b1;
    Instruction = I_ADDI;
    @(negedge Clk);
    chk("rst_ready", 64'(InReady), 64'd0);
    tick();
    chk("rst_ready2", 64'(InReady), 64'd0);
    chk("rst_outs", 64'(obs1()), 64'({3'b000, RSTW, 32'h0}));
    Rst = 1'b0;
    InValid = 1'b0;

    // decode table, each entry from a clean reset
    foreach (tbl[k]) begin
      do_reset();
      Instruction = tbl[k].ins;
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      chk({"tbl_", tbl[k].nm},
          64'({OutValid, IllegalOp, cw1(), InstructionToALU}),
          64'({1'b1, tbl[k].ill, tbl[k].cw, tbl[k].ins}));
    end

    // mult then mflo: blocked while the HI/LO unit is busy
    do_reset();
    Instruction = I_MULT;
    InValid = 1'b1;
    tick();
    Instruction = I_MFLO;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mul_busy", 64'({MulBusy, InReady}), 64'(2'b10));
      tick();
    end
    #1;
    chk("mul_done", 64'({MulBusy, InReady}), 64'(2'b01));
    tick();
    InValid = 1'b0;
    chk("mflo_acc", 64'({OutValid, RegWrite, InstructionToALU}),
        64'({2'b11, I_MFLO}));

    // lw held through a 3-cycle stall, then flushed during the stall
    do_reset();
    Instruction = I_LW;
    InValid = 1'b1;
    tick();
    Instruction = I_ADDI;
    Stall = 1'b1;
    #1;
    chk("stall_ready", 64'(InReady), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("stall_hold", 64'(obs1()),
          64'({3'b100, 13'b1100000100010, I_LW}));
      if (k < 3) tick();
    end
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    Stall = 1'b0;
    InValid = 1'b0;
    chk("flush_bubble", 64'(obs1()),
        64'({3'b000, 13'b0100000100010, I_LW}));

    // illegal opcode pulses for exactly one cycle
    do_reset();
    Instruction = I_ILL;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    chk("ill_pulse", 64'(obs1()), 64'({3'b110, NOPW, I_ILL}));
    tick();
    chk("ill_clear", 64'(obs1()), 64'({3'b000, NOPW, I_ILL}));

    // madd: legal and busy with ENABLE_MADD=1, illegal with 0
    do_reset();
    Instruction = I_MADD;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    chk("madd_en1", 64'({OutValid, IllegalOp, MulBusy, cw1()}),
        64'({3'b101, 13'b0000100001010}));
    chk("madd_en0", 64'({d2_OutValid, d2_IllegalOp, d2_MulBusy, cw2()}),
        64'({3'b110, NOPW}));

    // reset in the middle of a HI/LO op
    do_reset();
    Instruction = I_MULT;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    chk("mid_busy", 64'(MulBusy), 64'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    Instruction = I_MFLO;
    InValid = 1'b1;
    #1;
    chk("rst_busy_clr", 64'({MulBusy, InReady}), 64'(2'b01));
    tick();
    InValid = 1'b0;
    chk("rst_mflo_acc", 64'({OutValid, InstructionToALU}),
        64'({1'b1, I_MFLO}));

    // random traffic against the reference model
    Rst = 1'b1;
    InValid = 1'b0;
    tick();
    Rst = 1'b0;
    m_vld = 0;
    m_ill = 0;
    m_cw = RSTW;
    m_ins = '0;
    m_busy = 0;
    for (int n = 0; n < 800; n++) rstep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
